// File: rtl/load_align_unit.sv
// Load data unit between MEM and WB: issues aligned word reads, splits loads that
// straddle a bus word into two reads, then merges, aligns and extends the data.
module load_align_unit #(
   parameter int XLEN           = 32,
   parameter int MISALIGN_SPLIT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [31:0]     req_addr,
   input  logic [4:0]      req_rd,
   output logic            mem_req,
   output logic [31:0]     mem_addr,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd,
   output logic            out_misalign
);

   localparam int BYTES = XLEN / 8;
   localparam int OFFW  = $clog2(BYTES);

   typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

   state_t          state;
   state_t          state_nxt;

   logic [OFFW-1:0] req_off;
   logic [3:0]      req_size;
   logic            req_illegal;
   logic            req_misal;
   logic            req_cross;
   logic            req_reject;

   logic [2:0]      funct3_q;
   logic [OFFW-1:0] off_q;
   logic            cross_q;
   logic [XLEN-1:0] lo_q;

   // Shift the {hi,lo} pair down to the addressed byte, keep the access size and
   // extend: the field is parked at the top of a signed word so that a right shift
   // back down either zero-fills (unsigned) or replicates the top byte's sign bit.
   function automatic logic [XLEN-1:0] align_extend(input logic [2*XLEN-1:0] pair,
                                                    input logic [OFFW-1:0]   off,
                                                    input logic [2:0]        f3);
      logic [2*XLEN-1:0]      shifted;
      logic signed [XLEN-1:0] field;
      int                     fbits;
      int                     pad;
      shifted = pair >> {off, 3'b000};
      fbits   = 8 << f3[1:0];
      pad     = (fbits >= XLEN) ? 0 : XLEN - fbits;
      field   = shifted[XLEN-1:0] << pad;
      if (f3[2]) begin
         return field >> pad;
      end
      return field >>> pad;
   endfunction

   // Request decode: size, offset in the bus word, misalignment, word crossing, legality.
   always_comb begin
      req_off     = req_addr[OFFW-1:0];
      req_size    = 4'd1 << req_funct3[1:0];
      req_illegal = (req_funct3 == 3'b111) ||
                    ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
      req_misal   = ((4'(req_off)) & (req_size - 4'd1)) != 4'd0;
      req_cross   = (5'(req_off) + 5'(req_size)) > 5'(BYTES);
      req_reject  = req_illegal || ((MISALIGN_SPLIT == 0) && req_misal);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake/strobe outputs.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      mem_req   = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = req_reject ? RESP : ISSUE0;
            end
         end
         ISSUE0: begin
            mem_req   = 1'b1;
            state_nxt = WAIT0;
         end
         WAIT0: begin
            if (mem_rvalid) begin
               state_nxt = cross_q ? ISSUE1 : RESP;
            end
         end
         ISSUE1: begin
            mem_req   = 1'b1;
            state_nxt = WAIT1;
         end
         WAIT1: begin
            if (mem_rvalid) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, read address sequencing and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr     <= '0;
         out_data     <= '0;
         out_rd       <= '0;
         out_misalign <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         cross_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_addr     <= req_addr & ~32'(BYTES - 1);
                  out_data     <= '0;
                  out_rd       <= req_rd;
                  out_misalign <= req_reject && !req_illegal;
                  funct3_q     <= req_funct3;
                  off_q        <= req_off;
                  cross_q      <= req_cross && !req_reject;
               end
            end
            WAIT0: begin
               if (mem_rvalid) begin
                  if (cross_q) begin
                     mem_addr <= mem_addr + 32'(BYTES);
                  end else begin
                     out_data <= align_extend({{XLEN{1'b0}}, mem_rdata}, off_q, funct3_q);
                  end
               end
            end
            WAIT1: begin
               if (mem_rvalid) begin
                  out_data <= align_extend({mem_rdata, lo_q}, off_q, funct3_q);
               end
            end
            default: ;
         endcase
      end
   end

   // Low word of a split access, held until the high word arrives.
   always_ff @(posedge clk) begin
      if (state == WAIT0 && mem_rvalid) begin
         lo_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three instances (XLEN=32 split, XLEN=32 reject, XLEN=64)
// share one driver, byte-addressed memory responder and scoreboard, selected by sel.
module tb_load_align_unit;

   typedef struct {
      int          sel;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [63:0] data;
      logic        mis;
      int          nreq;
      logic [31:0] a0;
      logic [31:0] a1;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        mis;
      int          nreq;
      logic [31:0] a0;
      logic [31:0] a1;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [4:0]  req_rd;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        out_ready;
   int          sel;
   int          mem_extra;

   logic        u0_req_ready, u0_mem_req, u0_out_valid, u0_out_misalign;
   logic [31:0] u0_mem_addr, u0_out_data;
   logic [4:0]  u0_out_rd;
   logic        u1_req_ready, u1_mem_req, u1_out_valid, u1_out_misalign;
   logic [31:0] u1_mem_addr, u1_out_data;
   logic [4:0]  u1_out_rd;
   logic        u2_req_ready, u2_mem_req, u2_out_valid, u2_out_misalign;
   logic [31:0] u2_mem_addr;
   logic [63:0] u2_out_data;
   logic [4:0]  u2_out_rd;

   logic        o_req_ready, o_mem_req, o_out_valid, o_out_misalign;
   logic [31:0] o_mem_addr;
   logic [63:0] o_out_data;
   logic [4:0]  o_out_rd;

   logic [7:0]  mem_b [logic [31:0]];
   exp_t        q[$];
   vec_t        vecs[$];
   int          nchecks = 0;
   int          nerr = 0;
   int          cyc = 0;
   int          memreq_cnt = 0;
   bit          seen = 0;
   int          first_cyc = 0;

   load_align_unit #(.XLEN(32), .MISALIGN_SPLIT(1)) u0 (
      .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(u0_req_ready),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_rd(req_rd),
      .mem_req(u0_mem_req), .mem_addr(u0_mem_addr), .mem_rvalid(mem_rvalid && sel == 0),
      .mem_rdata(mem_rdata[31:0]), .out_valid(u0_out_valid), .out_ready(out_ready),
      .out_data(u0_out_data), .out_rd(u0_out_rd), .out_misalign(u0_out_misalign));

   load_align_unit #(.XLEN(32), .MISALIGN_SPLIT(0)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(u1_req_ready),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_rd(req_rd),
      .mem_req(u1_mem_req), .mem_addr(u1_mem_addr), .mem_rvalid(mem_rvalid && sel == 1),
      .mem_rdata(mem_rdata[31:0]), .out_valid(u1_out_valid), .out_ready(out_ready),
      .out_data(u1_out_data), .out_rd(u1_out_rd), .out_misalign(u1_out_misalign));

   load_align_unit #(.XLEN(64), .MISALIGN_SPLIT(1)) u2 (
      .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2), .req_ready(u2_req_ready),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_rd(req_rd),
      .mem_req(u2_mem_req), .mem_addr(u2_mem_addr), .mem_rvalid(mem_rvalid && sel == 2),
      .mem_rdata(mem_rdata), .out_valid(u2_out_valid), .out_ready(out_ready),
      .out_data(u2_out_data), .out_rd(u2_out_rd), .out_misalign(u2_out_misalign));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Route the selected instance to the shared observation signals.
   always_comb begin
      o_req_ready = u0_req_ready; o_mem_req = u0_mem_req; o_out_valid = u0_out_valid;
      o_out_misalign = u0_out_misalign; o_mem_addr = u0_mem_addr;
      o_out_data = {32'h0, u0_out_data}; o_out_rd = u0_out_rd;
      if (sel == 1) begin
         o_req_ready = u1_req_ready; o_mem_req = u1_mem_req; o_out_valid = u1_out_valid;
         o_out_misalign = u1_out_misalign; o_mem_addr = u1_mem_addr;
         o_out_data = {32'h0, u1_out_data}; o_out_rd = u1_out_rd;
      end else if (sel == 2) begin
         o_req_ready = u2_req_ready; o_mem_req = u2_mem_req; o_out_valid = u2_out_valid;
         o_out_misalign = u2_out_misalign; o_mem_addr = u2_mem_addr;
         o_out_data = u2_out_data; o_out_rd = u2_out_rd;
      end
   end

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      return mem_b.exists(a) ? mem_b[a] : 8'h00;
   endfunction

   task automatic put_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      nchecks++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   // Byte-level reference: gather size bytes from memory and extend.
   function automatic logic [63:0] model(input int s, input logic [2:0] f3, input logic [31:0] a);
      int          size;
      logic [63:0] v;
      size = 1 << f3[1:0];
      v = '0;
      for (int b = 0; b < size; b++) v[8*b +: 8] = rd_byte(a + 32'(b));
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'h0 << (8*size));
      if (s != 2) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   // Memory responder: one read per strobe, data after 1 + mem_extra cycles.
   initial begin
      logic [31:0] a;
      int          s;
      int          d;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (o_mem_req && !rst) begin
            a = o_mem_addr; s = sel; d = mem_extra;
            repeat (1 + d) @(posedge clk);
            #1;
            mem_rvalid = 1'b1;
            mem_rdata  = '0;
            for (int i = 0; i < ((s == 2) ? 8 : 4); i++) mem_rdata[8*i +: 8] = rd_byte(a + 32'(i));
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
         end
      end
   end

   // Scoreboard monitor: read addresses, strobe count, result fields and latency.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (o_mem_req) begin
            if (q.size() > 0)
               chk("mem_addr", {32'h0, o_mem_addr}, {32'h0, (memreq_cnt == 0) ? q[0].a0 : q[0].a1});
            memreq_cnt++;
         end
         if (o_out_valid && !seen) begin
            seen = 1;
            first_cyc = cyc;
         end
         if (o_out_valid && out_ready) begin
            if (q.size() == 0) begin
               nchecks++; nerr++;
               $display("FAIL unexpected_out: out_valid=1 with data %h, required no result", o_out_data);
            end else begin
               e = q.pop_front();
               chk("out_data", o_out_data, e.data);
               chk("out_rd", 64'(o_out_rd), 64'(e.rd));
               chk("out_misalign", 64'(o_out_misalign), 64'(e.mis));
               chk("mem_req_count", 64'(memreq_cnt), 64'(e.nreq));
               chk("latency", 64'(first_cyc - e.acc), 64'(e.lat));
            end
            seen = 0;
            memreq_cnt = 0;
         end
      end
   end

   task automatic issue(input int s, input logic [2:0] f3, input logic [31:0] a, input exp_t e,
                        input bit push);
      bit ok;
      ok = 0;
      sel = s; req_funct3 = f3; req_addr = a; req_rd = e.rd; req_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (o_req_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         nchecks++; nerr++;
         $display("FAIL accept_timeout: req_ready=0, required 1");
      end else begin
         e.acc = cyc;
         e.lat = (e.nreq == 0) ? 1 : (e.nreq == 1) ? 3 + mem_extra : 5 + 2 * mem_extra;
         if (push) q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (q.size() == 0 && o_req_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         nchecks++; nerr++;
         $display("FAIL result_timeout: %0d results outstanding, required 0", q.size());
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input vec_t v, input logic [4:0] rd);
      exp_t e;
      e.data = v.data; e.rd = rd; e.mis = v.mis; e.nreq = v.nreq;
      e.a0 = v.a0; e.a1 = v.a1; e.lat = 0; e.acc = 0;
      return e;
   endfunction

   initial begin
      logic [2:0] f32 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0] f64 [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
      vec_t       v;
      exp_t       e;
      int         nb;
      int         sz;
      int         seen_req;

      rst = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rd = '0;
      out_ready = 1'b1; sel = 0; mem_extra = 0;

      put_word(32'h100, 32'h80FF_1234); put_word(32'h104, 32'h8877_6655);
      put_word(32'h108, 32'hCCBB_AA99); put_word(32'h10C, 32'h1122_3344);
      put_word(32'h110, 32'h7766_5544); put_word(32'h200, 32'h8001_5678);
      put_word(32'hFFFF_FFFC, 32'hDDCC_BBAA); put_word(32'h0, 32'h0403_0201);
      put_word(32'h4, 32'h8000_0001);
      for (int a = 32'h300; a < 32'h348; a++) mem_b[32'(a)] = 8'($urandom);

      vecs.push_back('{0, 3'b000, 32'h103, 64'hFFFF_FF80, 1'b0, 1, 32'h100, 32'h0});
      vecs.push_back('{0, 3'b101, 32'h202, 64'h0000_8001, 1'b0, 1, 32'h200, 32'h0});
      vecs.push_back('{0, 3'b001, 32'h202, 64'hFFFF_8001, 1'b0, 1, 32'h200, 32'h0});
      vecs.push_back('{0, 3'b010, 32'h106, 64'hAA99_8877, 1'b0, 2, 32'h104, 32'h108});
      vecs.push_back('{0, 3'b100, 32'h103, 64'h0000_0080, 1'b0, 1, 32'h100, 32'h0});
      vecs.push_back('{0, 3'b000, 32'h100, 64'h0000_0034, 1'b0, 1, 32'h100, 32'h0});
      vecs.push_back('{0, 3'b001, 32'h101, 64'hFFFF_FF12, 1'b0, 1, 32'h100, 32'h0});
      vecs.push_back('{0, 3'b001, 32'h107, 64'hFFFF_9988, 1'b0, 2, 32'h104, 32'h108});
      vecs.push_back('{0, 3'b101, 32'h107, 64'h0000_9988, 1'b0, 2, 32'h104, 32'h108});
      vecs.push_back('{0, 3'b010, 32'h104, 64'h8877_6655, 1'b0, 1, 32'h104, 32'h0});
      vecs.push_back('{0, 3'b011, 32'h100, 64'h0, 1'b0, 0, 32'h0, 32'h0});
      vecs.push_back('{0, 3'b110, 32'h100, 64'h0, 1'b0, 0, 32'h0, 32'h0});
      vecs.push_back('{0, 3'b111, 32'h104, 64'h0, 1'b0, 0, 32'h0, 32'h0});
      vecs.push_back('{0, 3'b010, 32'hFFFF_FFFE, 64'h0201_DDCC, 1'b0, 2, 32'hFFFF_FFFC, 32'h0});
      vecs.push_back('{0, 3'b010, 32'h105, 64'h9988_7766, 1'b0, 2, 32'h104, 32'h108});
      vecs.push_back('{0, 3'b100, 32'h109, 64'h0000_00AA, 1'b0, 1, 32'h108, 32'h0});
      vecs.push_back('{1, 3'b010, 32'h102, 64'h0, 1'b1, 0, 32'h0, 32'h0});
      vecs.push_back('{1, 3'b001, 32'h101, 64'h0, 1'b1, 0, 32'h0, 32'h0});
      vecs.push_back('{1, 3'b001, 32'h202, 64'hFFFF_8001, 1'b0, 1, 32'h200, 32'h0});
      vecs.push_back('{1, 3'b111, 32'h101, 64'h0, 1'b0, 0, 32'h0, 32'h0});
      vecs.push_back('{1, 3'b000, 32'h103, 64'hFFFF_FF80, 1'b0, 1, 32'h100, 32'h0});
      vecs.push_back('{2, 3'b110, 32'h4, 64'h0000_0000_8000_0001, 1'b0, 1, 32'h0, 32'h0});
      vecs.push_back('{2, 3'b010, 32'h4, 64'hFFFF_FFFF_8000_0001, 1'b0, 1, 32'h0, 32'h0});
      vecs.push_back('{2, 3'b111, 32'h4, 64'h0, 1'b0, 0, 32'h0, 32'h0});
      vecs.push_back('{2, 3'b011, 32'h0, 64'h8000_0001_0403_0201, 1'b0, 1, 32'h0, 32'h0});
      vecs.push_back('{2, 3'b011, 32'h104, 64'hCCBB_AA99_8877_6655, 1'b0, 2, 32'h100, 32'h108});
      vecs.push_back('{2, 3'b001, 32'h107, 64'hFFFF_FFFF_FFFF_9988, 1'b0, 2, 32'h100, 32'h108});
      vecs.push_back('{2, 3'b110, 32'h10E, 64'h0000_0000_5544_1122, 1'b0, 2, 32'h108, 32'h110});
      vecs.push_back('{2, 3'b100, 32'h10F, 64'h0000_0000_0000_0011, 1'b0, 1, 32'h108, 32'h0});

      // Reset state
      repeat (2) @(negedge clk);
      sel = 0; #1;
      chk("rst_req_ready", 64'(o_req_ready), 64'd1);
      chk("rst_mem_req", 64'(o_mem_req), 64'd0);
      chk("rst_out_valid", 64'(o_out_valid), 64'd0);
      chk("rst_out_misalign", 64'(o_out_misalign), 64'd0);
      chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
      chk("rst_out_data", o_out_data, 64'd0);
      chk("rst_out_rd", 64'(o_out_rd), 64'd0);
      sel = 2; #1;
      chk("rst_out_data64", o_out_data, 64'd0);
      sel = 0;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      foreach (vecs[i]) begin
         v = vecs[i];
         issue(v.sel, v.f3, v.addr, mk(v, 5'(i + 1)), 1'b1);
         wait_done();
      end

      // Random loads against the byte model, with variable memory delay
      for (int i = 0; i < 16; i++) begin
         v.sel  = (i % 2 == 0) ? 0 : 2;
         nb     = (v.sel == 2) ? 8 : 4;
         v.f3   = (v.sel == 2) ? f64[$urandom_range(0, 6)] : f32[$urandom_range(0, 4)];
         v.addr = 32'h300 + 32'($urandom_range(0, 32'h37));
         sz     = 1 << v.f3[1:0];
         v.data = model(v.sel, v.f3, v.addr);
         v.mis  = 1'b0;
         v.nreq = ((int'(v.addr) % nb) + sz > nb) ? 2 : 1;
         v.a0   = v.addr & ~32'(nb - 1);
         v.a1   = v.a0 + 32'(nb);
         mem_extra = $urandom_range(0, 2);
         issue(v.sel, v.f3, v.addr, mk(v, 5'(i)), 1'b1);
         wait_done();
      end
      mem_extra = 0;

      // Back-pressure: result held stable while out_ready is low
      out_ready = 1'b0;
      v = '{0, 3'b010, 32'h104, 64'h8877_6655, 1'b0, 1, 32'h104, 32'h0};
      issue(0, v.f3, v.addr, mk(v, 5'd9), 1'b1);
      for (int k = 0; k < 20 && !o_out_valid; k++) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("stall_out_valid", 64'(o_out_valid), 64'd1);
         chk("stall_out_data", o_out_data, 64'h8877_6655);
         chk("stall_req_ready", 64'(o_req_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_out_valid", 64'(o_out_valid), 64'd0);
      chk("release_req_ready", 64'(o_req_ready), 64'd1);
      @(posedge clk); #1;

      // Reset during the second read of a split load; late read data must be ignored
      mem_extra = 3;
      v = '{0, 3'b010, 32'h106, 64'h0, 1'b0, 2, 32'h104, 32'h108};
      issue(0, v.f3, v.addr, mk(v, 5'd7), 1'b0);
      seen_req = 1;
      for (int k = 0; k < 30 && seen_req < 2; k++) begin
         @(negedge clk);
         if (o_mem_req) seen_req++;
      end
      chk("abort_second_req", 64'(seen_req), 64'd2);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      chk("abort_req_ready", 64'(o_req_ready), 64'd1);
      chk("abort_out_valid", 64'(o_out_valid), 64'd0);
      @(posedge clk); #1; rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("abort_quiet", {62'h0, o_out_valid, o_mem_req}, 64'd0);
      end
      memreq_cnt = 0;
      mem_extra = 0;
      @(posedge clk); #1;
      v = '{0, 3'b000, 32'h103, 64'hFFFF_FF80, 1'b0, 1, 32'h100, 32'h0};
      issue(0, v.f3, v.addr, mk(v, 5'd31), 1'b1);
      wait_done();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
